uart_cmd_decoder: RTL and testbench

//  Host-side master for uart_fifo. Pulls received bytes through the fifo req/nwr/ack port and parses 5-byte command

---
 rtl/uart_cmd_pkg.sv | 12 +
 rtl/uart_fifo_port.sv | 73 +++++++
 rtl/uart_cmd_decoder.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame constants and state encodings shared by the command decoder and its fifo port.
package uart_cmd_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'h5A;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;
    typedef enum logic [3:0] {
        IDLE, RX_REQ, RX_REL, PARSE, EXEC, REG_RD, TX_WAIT, TX_REQ, TX_REL
    } state_e;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_REQ, P_REL} port_state_e;
endpackage

// File: rtl/uart_fifo_port.sv
// uart_fifo_port: 4-phase req/ack master toward uart_fifo; one start gives one done after the handshake closes.
module uart_fifo_port
    import uart_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       nwr_i,
    input  logic [7:0] wdata_i,
    input  logic       full_i,
    input  logic       ack_i,
    input  logic [7:0] rdata_i,
    output logic       req_o,
    output logic       nwr_o,
    output logic [7:0] wdata_o,
    output logic       done_o,
    output logic [7:0] rdata_o
);
    port_state_e st_q, st_d;
    logic       req_q, req_d, nwr_q, nwr_d, done_q, done_d;
    logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q    <= P_IDLE;
            req_q   <= 1'b0;
            nwr_q   <= 1'b0;
            done_q  <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            st_q    <= st_d;
            req_q   <= req_d;
            nwr_q   <= nwr_d;
            done_q  <= done_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // nwr/wdata settle a clock before req rises; a write never raises req into a full TX fifo
    always_comb begin
        st_d    = st_q;
        req_d   = req_q;
        nwr_d   = nwr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (st_q)
            P_IDLE: if (start_i) begin
                nwr_d   = nwr_i;
                wdata_d = wdata_i;
                st_d    = P_SETUP;
            end
            P_SETUP: if (!ack_i && (nwr_q || !full_i)) begin
                req_d = 1'b1;
                st_d  = P_REQ;
            end
            P_REQ: if (ack_i) begin
                rdata_d = nwr_q ? rdata_i : rdata_q;
                req_d   = 1'b0;
                st_d    = P_REL;
            end
            default: if (!ack_i) begin
                done_d = 1'b1;
                st_d   = P_IDLE;
            end
        endcase
    end
    assign req_o   = req_q;
    assign nwr_o   = nwr_q;
    assign wdata_o = wdata_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: pulls 5A/CMD/ADDR/DATA/CHK frames from uart_fifo, runs them on the register bus,
// and pushes back one reply byte (ACK, NAK or read data).
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_BITS   = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       fifo_req_o,
    output logic       fifo_nwr_o,
    input  logic       fifo_ack_i,
    output logic [7:0] fifo_wdata_o,
    input  logic [7:0] fifo_rdata_i,
    input  logic       fifo_full_i,
    input  logic       fifo_empty_i,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic [7:0] err_count_o,
    output logic       busy_o
);
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [7:0]              cmd_q, cmd_d, adr_q, adr_d, dat_q, dat_d, reply_q, reply_d;
    logic [7:0]              addr_q, addr_d, wdata_q, wdata_d, err_q, err_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    rd_ph_q, rd_ph_d;
    logic                    port_done, tmo_hit, frame_ok;
    logic [7:0]              rx_byte, err_sat;
    uart_fifo_port u_port (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (state_q == RX_REQ || state_q == TX_REQ),
        .nwr_i   (state_q == RX_REQ),
        .wdata_i (reply_q),
        .full_i  (fifo_full_i),
        .ack_i   (fifo_ack_i),
        .rdata_i (fifo_rdata_i),
        .req_o   (fifo_req_o),
        .nwr_o   (fifo_nwr_o),
        .wdata_o (fifo_wdata_o),
        .done_o  (port_done),
        .rdata_o (rx_byte)
    );
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cmd_q   <= 8'h00;
            adr_q   <= 8'h00;
            dat_q   <= 8'h00;
            reply_q <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            err_q   <= 8'h00;
            tmo_q   <= '0;
            rd_ph_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            reply_q <= reply_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            rd_ph_q <= rd_ph_d;
        end
    end
    assign tmo_hit  = tmo_q == TMO_LAST;
    assign err_sat  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    assign frame_ok = rx_byte == (cmd_q ^ adr_q ^ dat_q) && (cmd_q == CMD_WR || cmd_q == CMD_RD);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        reply_d = reply_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        rd_ph_d = rd_ph_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_i) begin
                    state_d = RX_REQ;
                end else if (idx_q != 3'd0) begin
                    tmo_d = tmo_hit ? '0 : tmo_q + TIMEOUT_BITS'(1);
                    idx_d = tmo_hit ? 3'd0 : idx_q;
                    err_d = tmo_hit ? err_sat : err_q;
                end
            end
            RX_REQ: state_d = RX_REL;
            RX_REL: state_d = port_done ? PARSE : RX_REL;
            PARSE: begin
                state_d = IDLE;
                tmo_d   = '0;
                idx_d   = idx_q + 3'd1;
                // inside a frame every byte is a field, so a 0x5A there never resyncs
                case (idx_q)
                    3'd0: idx_d = (rx_byte == SYNC_BYTE) ? 3'd1 : 3'd0;
                    3'd1: cmd_d = rx_byte;
                    3'd2: adr_d = rx_byte;
                    3'd3: dat_d = rx_byte;
                    default: begin
                        idx_d   = 3'd0;
                        state_d = frame_ok ? EXEC : TX_WAIT;
                        reply_d = frame_ok ? REPLY_ACK : REPLY_NAK;
                        err_d   = frame_ok ? err_q : err_sat;
                        addr_d  = frame_ok ? adr_q : addr_q;
                        wdata_d = (frame_ok && cmd_q == CMD_WR) ? dat_q : wdata_q;
                    end
                endcase
            end
            EXEC: state_d = (cmd_q == CMD_RD) ? REG_RD : TX_WAIT;
            // first REG_RD clock strobes, second captures the register's answer
            REG_RD: begin
                rd_ph_d = !rd_ph_q;
                reply_d = rd_ph_q ? reg_rdata_i : reply_q;
                state_d = rd_ph_q ? TX_WAIT : REG_RD;
            end
            TX_WAIT: state_d = fifo_full_i ? TX_WAIT : TX_REQ;
            TX_REQ:  state_d = TX_REL;
            TX_REL:  state_d = port_done ? IDLE : TX_REL;
            default: state_d = IDLE;
        endcase
    end
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = state_q == EXEC && cmd_q == CMD_WR;
    assign reg_rd_o    = state_q == REG_RD && !rd_ph_q;
    assign err_count_o = err_q;
    assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: behavioural uart_fifo and register file around the decoder, scoreboarded replies and strobes.
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;
    logic       clk = 1'b0, reset = 1'b1;
    logic       fifo_req, fifo_nwr, fifo_ack = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1;
    logic [7:0] fifo_wdata, fifo_rdata = 8'h00;
    logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00, err_count;
    logic       reg_wr, reg_rd, busy, req_prev = 1'b0;
    logic [7:0] rx_fifo[$];
    logic [7:0] exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rf[256];
    logic [7:0] mdl[256];
    int vectors = 0, miscompares = 0, exp_err = 0, dly = 0;
    always #5 clk = ~clk;
    uart_cmd_decoder dut (
        .clk_i(clk), .reset_i(reset),
        .fifo_req_o(fifo_req), .fifo_nwr_o(fifo_nwr), .fifo_ack_i(fifo_ack),
        .fifo_wdata_o(fifo_wdata), .fifo_rdata_i(fifo_rdata),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wr_o(reg_wr), .reg_rd_o(reg_rd),
        .reg_rdata_i(reg_rdata), .err_count_o(err_count), .busy_o(busy)
    );
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // fifo responder with a random ack latency
    always @(posedge clk) begin
        if (reset) begin
            fifo_ack <= 1'b0;
        end else if (fifo_req && !fifo_ack) begin
            if (dly != 0) begin
                dly <= dly - 1;
            end else begin
                fifo_ack <= 1'b1;
                if (fifo_nwr && rx_fifo.size() != 0) fifo_rdata <= rx_fifo.pop_front();
                dly <= int'($urandom_range(0, 3));
            end
        end else if (!fifo_req && fifo_ack) begin
            fifo_ack <= 1'b0;
        end
        fifo_empty <= rx_fifo.size() == 0;
    end
    always @(posedge clk) begin
        if (reg_wr) rf[reg_addr] <= reg_wdata;
        if (reg_rd) reg_rdata <= rf[reg_addr];
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr) begin
                if (exp_wr.size() == 0) check("unexpected_reg_wr", 16'd1, 16'd0);
                else check("reg_wr_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
            end
            if (reg_rd) begin
                if (exp_rd.size() == 0) check("unexpected_reg_rd", 16'd1, 16'd0);
                else check("reg_rd_addr", {8'h00, reg_addr}, {8'h00, exp_rd.pop_front()});
            end
            if (fifo_req && fifo_ack && !fifo_nwr) begin
                if (exp_tx.size() == 0) check("unexpected_reply", {8'h00, fifo_wdata}, 16'hFFFF);
                else check("reply_byte", {8'h00, fifo_wdata}, {8'h00, exp_tx.pop_front()});
            end
            if (fifo_req && !req_prev && !fifo_nwr) check("tx_req_while_full", {15'd0, fifo_full}, 16'd0);
        end
        req_prev <= fifo_req;
    end
    task automatic send(input logic [39:0] f, input int n);
        @(negedge clk);
        for (int i = n - 1; i >= 0; i--) rx_fifo.push_back(f[i*8+:8]);
    endtask
    task automatic expect_frame(input logic [7:0] c, a, d, k);
        if (k == (c ^ a ^ d) && c == CMD_WR) begin
            exp_wr.push_back({a, d});
            mdl[a] = d;
            exp_tx.push_back(REPLY_ACK);
        end else if (k == (c ^ a ^ d) && c == CMD_RD) begin
            exp_rd.push_back(a);
            exp_tx.push_back(mdl[a]);
        end else begin
            exp_tx.push_back(REPLY_NAK);
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        end
    endtask
    task automatic frame(input logic [7:0] c, a, d, k);
        expect_frame(c, a, d, k);
        send({SYNC_BYTE, c, a, d, k}, 5);
    endtask
    task automatic settle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rx_fifo.size() != 0 || busy || exp_tx.size() != 0) && n < 5000);
        if (n >= 5000) check({tag, "_settle_timeout"}, 16'd1, 16'd0);
        check({tag, "_err_count"}, {8'h00, err_count}, 16'(exp_err));
    endtask
    initial begin
        for (int i = 0; i < 256; i++) begin
            rf[i]  = 8'(i) ^ 8'hA5;
            mdl[i] = 8'(i) ^ 8'hA5;
        end
        repeat (3) @(negedge clk);
        check("rst_fifo_req", {15'd0, fifo_req}, 16'd0);
        check("rst_fifo_nwr_wdata", {7'd0, fifo_nwr, fifo_wdata}, 16'd0);
        check("rst_reg_bus", {reg_addr, reg_wdata}, 16'd0);
        check("rst_strobes_busy", {13'd0, reg_wr, reg_rd, busy}, 16'd0);
        check("rst_err_count", {8'h00, err_count}, 16'd0);
        reset = 1'b0;
        frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        settle("wr10");
        check("wr10_bus_hold", {reg_addr, reg_wdata}, 16'h103C);
        frame(8'h02, 8'h10, 8'h00, 8'h12);
        settle("rd10");
        frame(8'h01, 8'h10, 8'h3C, 8'h00);
        settle("bad_chk");
        send(40'h1122, 2);
        frame(8'h02, 8'h20, 8'h00, 8'h22);
        settle("garbage_rd20");
        frame(8'h07, 8'h00, 8'h00, 8'h07);
        settle("bad_cmd");
        frame(8'h01, 8'h5A, 8'h5A, 8'h01);
        settle("sync_as_data");
        send({SYNC_BYTE, CMD_WR}, 2);
        settle("slow_hdr");
        repeat (900) @(negedge clk);
        check("slow_err_held", {8'h00, err_count}, 16'(exp_err));
        expect_frame(8'h01, 8'h33, 8'h44, 8'h76);
        send(40'h334476, 3);
        settle("slow_tail");
        send({SYNC_BYTE, CMD_WR}, 2);
        settle("tmo_hdr");
        repeat (1100) @(negedge clk);
        exp_err++;
        check("tmo_busy", {15'd0, busy}, 16'd0);
        check("tmo_err_count", {8'h00, err_count}, 16'(exp_err));
        frame(8'h02, 8'h33, 8'h00, 8'h31);
        settle("after_tmo");
        fifo_full = 1'b1;
        frame(8'h01, 8'h50, 8'h60, 8'h31);
        for (int n = 0; n < 200 && rx_fifo.size() != 0; n++) @(negedge clk);
        repeat (40) @(negedge clk);
        check("full_busy_req", {14'd0, busy, fifo_req}, 16'd2);
        fifo_full = 1'b0;
        settle("full_release");
        send({SYNC_BYTE, CMD_WR, 24'h112233}, 5);
        for (int n = 0; n < 100 && !fifo_req; n++) @(negedge clk);
        check("pre_reset_req_seen", {15'd0, fifo_req}, 16'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_req_busy", {14'd0, fifo_req, busy}, 16'd0);
        check("reset_err_count", {8'h00, err_count}, 16'd0);
        rx_fifo.delete();
        exp_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        frame(8'h02, 8'h5A, 8'h00, 8'h58);
        settle("post_reset_rd");
        check("left_tx", 16'(exp_tx.size()), 16'd0);
        check("left_wr_rd", 16'(exp_wr.size() + exp_rd.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
